// File: rtl/jk_counter_pkg.sv
// Shared JK flip-flop types and the excitation function used by the JK-based counters.
package jk_counter_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    CLR    = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_action_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  // J sets a bit that must rise, K clears a bit that must fall; unchanged bits get HOLD.
  function automatic jk_drive_t jk_excite(input logic cur, input logic nxt);
    jk_drive_t d;
    d.j = nxt & ~cur;
    d.k = ~nxt & cur;
    return d;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop, asynchronous active-high reset to 0.
module jk_ff
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_action_e act;
  assign act = jk_action_e'({j, k});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case (act)
        HOLD:    q <= q;
        CLR:     q <= 1'b0;
        SET:     q <= 1'b1;
        TOGGLE:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter built from JK flip-flops, with parallel load,
// wrap-or-saturate range ends and registered wrap/sat event pulses.
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam int unsigned NW = WIDTH + 1;
  localparam logic [WIDTH:0] TOP_EXT = NW'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD_EXT = NW'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] next;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   nxt_ext;
  logic             load_over;
  logic             at_top;
  logic             at_bottom;
  logic             count_end;
  logic             unused_msb;

  assign q          = q_bits;
  assign q_ext      = {1'b0, q_bits};
  assign load_over  = ({1'b0, load_val} >= MOD_EXT);
  assign at_top     = (q_bits == TOP);
  assign at_bottom  = (q_bits == '0);
  assign tc         = up ? at_top : at_bottom;
  assign count_end  = en & ~load & tc;

  // Next-count: load beats enable beats hold; arithmetic one bit wider than the count.
  always_comb begin
    nxt_ext = q_ext;
    if (load) begin
      nxt_ext = load_over ? TOP_EXT : {1'b0, load_val};
    end else if (en) begin
      if (up) begin
        if (at_top) nxt_ext = (SATURATE != 0) ? q_ext : '0;
        else        nxt_ext = q_ext + NW'(1);
      end else begin
        if (at_bottom) nxt_ext = (SATURATE != 0) ? q_ext : TOP_EXT;
        else           nxt_ext = q_ext - NW'(1);
      end
    end
  end

  assign next       = nxt_ext[WIDTH-1:0];
  assign unused_msb = nxt_ext[WIDTH];

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_drive_t drv;
    assign drv = jk_excite(q_bits[i], next[i]);

    jk_ff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (drv.j),
      .k     (drv.k),
      .q     (q_bits[i])
    );
  end

  // Range-end event pulses, one cycle after the count that hit the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else begin
      wrap <= count_end & (SATURATE == 0);
      sat  <= count_end & (SATURATE != 0);
    end
  end

endmodule
